l1_mem_arbiter: RTL and testbench
=================================

// Module: l1_mem_arbiter
// PURPOSE
//  Sits directly below the L1 caches: merges two L1 lower-memory ports (port 0 = L1 instruction,
//  port 1 = L1 data, writeback and fill) onto one lower-memory port. Round-robin arbitration.
//  One outstanding transaction at a time. Level-request / ready-pulse handshake on every port.
//  Optional timeout watchdog so a dead memory cannot hang a cache.
// PARAMETERS
//  ADDR_WIDTH      32   address width, all ports
//  DATA_WIDTH      32   data width, all ports
//  TIMEOUT_CYCLES  256  max cycles in ISSUE before forced completion; 0 = watchdog disabled
// PORTS
//  clk                   in   1    clock, all state updates on rising edge
//  rst                   in   1    synchronous reset, active-high
//  pN_mem_request        in   1    (N=0,1) request held high until pN_mem_ready is seen
//  pN_mem_write_enable   in   1    1 = write, 0 = read; held stable with the request
//  pN_mem_address        in   AW   request address; held stable with the request
//  pN_mem_write_data     in   DW   write data; held stable with the request
//  pN_mem_response_data  out  DW   read data; valid only while pN_mem_ready=1
//  pN_mem_ready          out  1    one-cycle completion pulse to the granted port
//  mem_request           out  1    downstream request level
//  mem_write_enable      out  1    downstream write select
//  mem_address           out  AW   downstream address
//  mem_write_data        out  DW   downstream write data
//  mem_response_data     in   DW   downstream read data, sampled when mem_ready=1
//  mem_ready             in   1    downstream completion pulse
//  timeout_err           out  1    sticky; set on any watchdog expiry
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, last_grant=1 (port 0 wins the first tie), watchdog=0.
//  All outputs are registered. No combinational path from input to output.
//  FSM:
//   IDLE  - if any pN_mem_request: pick winner; latch its we/addr/wdata into the downstream regs;
//           mem_request<=1; go to ISSUE. Otherwise stay.
//   ISSUE - hold mem_* stable; increment watchdog.
//           mem_ready=1: capture mem_response_data (0 for writes); mem_request<=0;
//           pN_mem_ready<=1 for the winner; go to RESP.
//           watchdog reaches TIMEOUT_CYCLES (nonzero) with no mem_ready: same as above,
//           but response data=0 and timeout_err<=1.
//   RESP  - ready/data are high for exactly this one cycle; then clear both to 0; watchdog=0;
//           go to IDLE. Requests are not sampled in RESP.
//  Arbitration:
//   - Only one port requests: it wins.
//   - Both request: the port that is not last_grant wins.
//   - last_grant updates on every grant.
//  Latency:
//   - Request seen in IDLE at cycle N: mem_request=1 from cycle N+1.
//   - mem_ready at cycle M: pN_mem_ready=1 at cycle M+1; mem_request=0 from M+1.
//   - Earliest next grant: IDLE at M+2, so mem_request again at M+3.
//  The losing port's request stays pending and is untouched; it is granted at the next IDLE.
//  The non-granted port's ready/response_data stay 0 at all times.
//  mem_ready outside ISSUE is ignored.
//  Requester inputs are not re-sampled after the grant; a port dropping its request mid-ISSUE
//   does not abort the downstream transaction.
//  rst during ISSUE/RESP: abandon at once (no ready pulse), all registers to reset values.
//  The watchdog counter is wide enough for TIMEOUT_CYCLES with no wrap. It saturates when the
//   watchdog is disabled.
//  timeout_err is cleared only by rst.
// TESTING
//  1. p0 read 0x0000_0040; mem_ready 3 cycles after mem_request rises, data 0xCAFE_0001
//     -> mem_address=0x40, mem_write_enable=0; p0_mem_ready one cycle with 0xCAFE_0001.
//  2. p0 and p1 request in the same cycle after reset -> p0 granted first, then p1.
//     Repeat the tie -> p1 first (round robin). Never two readies in one cycle.
//  3. p1 write addr 0x0000_1004, data 0x1234_5678, then p1 read 0x0000_2000 back-to-back
//     -> writeback completes before the fill issues; p1_mem_write_data passes through unchanged.
//  4. TIMEOUT_CYCLES=8, mem_ready never asserted -> p0_mem_ready after 8 ISSUE cycles,
//     data 0, timeout_err=1 and stays 1 until rst.
//  5. rst asserted 2 cycles into ISSUE -> next cycle mem_request=0, no pN_mem_ready, IDLE;
//     a new request is then granted normally.
//  6. Spurious mem_ready pulse while IDLE -> no state change, no ready outputs.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// Merges the L1 instruction (port 0) and L1 data (port 1) lower-memory ports onto one
// downstream port; round-robin, one transaction in flight, all outputs registered.
module l1_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_mem_request,
  input  logic                  p0_mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] p0_mem_address,
  input  logic [DATA_WIDTH-1:0] p0_mem_write_data,
  output logic [DATA_WIDTH-1:0] p0_mem_response_data,
  output logic                  p0_mem_ready,
  input  logic                  p1_mem_request,
  input  logic                  p1_mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] p1_mem_address,
  input  logic [DATA_WIDTH-1:0] p1_mem_write_data,
  output logic [DATA_WIDTH-1:0] p1_mem_response_data,
  output logic                  p1_mem_ready,
  output logic                  mem_request,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_response_data,
  input  logic                  mem_ready,
  output logic                  timeout_err
);

  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic [WDW-1:0]        wdog_q, wdog_d;
  logic                  mem_request_q, mem_request_d;
  logic                  mem_write_enable_q, mem_write_enable_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic                  p0_ready_q, p0_ready_d;
  logic                  p1_ready_q, p1_ready_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  grant;
  logic                  wdog_hit;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    winner_d           = winner_q;
    wdog_d             = wdog_q;
    mem_request_d      = mem_request_q;
    mem_write_enable_d = mem_write_enable_q;
    mem_address_d      = mem_address_q;
    mem_write_data_d   = mem_write_data_q;
    p0_ready_d         = p0_ready_q;
    p1_ready_d         = p1_ready_q;
    p0_rdata_d         = p0_rdata_q;
    p1_rdata_d         = p1_rdata_q;
    timeout_err_d      = timeout_err_q;
    grant              = 1'b0;
    wdog_hit           = 1'b0;
    resp_data          = '0;

    case (state_q)
      IDLE: begin
        if (p0_mem_request || p1_mem_request) begin
          // On a tie the port that was not served last goes first.
          grant              = (p0_mem_request && p1_mem_request) ? ~last_grant_q : p1_mem_request;
          winner_d           = grant;
          last_grant_d       = grant;
          mem_write_enable_d = grant ? p1_mem_write_enable : p0_mem_write_enable;
          mem_address_d      = grant ? p1_mem_address     : p0_mem_address;
          mem_write_data_d   = grant ? p1_mem_write_data  : p0_mem_write_data;
          mem_request_d      = 1'b1;
          wdog_d             = '0;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (WDOG_EN) begin
          wdog_d   = wdog_q + WDW'(1);
          wdog_hit = (wdog_d == WDOG_LIMIT);
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + WDW'(1);
        end
        if (mem_ready || wdog_hit) begin
          // A real completion wins over a watchdog expiry in the same cycle.
          resp_data     = (mem_ready && !mem_write_enable_q) ? mem_response_data : '0;
          timeout_err_d = timeout_err_q | ~mem_ready;
          mem_request_d = 1'b0;
          if (winner_q) begin
            p1_ready_d = 1'b1;
            p1_rdata_d = resp_data;
          end else begin
            p0_ready_d = 1'b1;
            p0_rdata_d = resp_data;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        p0_ready_d = 1'b0;
        p1_ready_d = 1'b0;
        p0_rdata_d = '0;
        p1_rdata_d = '0;
        wdog_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      last_grant_q       <= 1'b1;
      winner_q           <= 1'b0;
      wdog_q             <= '0;
      mem_request_q      <= 1'b0;
      mem_write_enable_q <= 1'b0;
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      p0_ready_q         <= 1'b0;
      p1_ready_q         <= 1'b0;
      p0_rdata_q         <= '0;
      p1_rdata_q         <= '0;
      timeout_err_q      <= 1'b0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      winner_q           <= winner_d;
      wdog_q             <= wdog_d;
      mem_request_q      <= mem_request_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      p0_ready_q         <= p0_ready_d;
      p1_ready_q         <= p1_ready_d;
      p0_rdata_q         <= p0_rdata_d;
      p1_rdata_q         <= p1_rdata_d;
      timeout_err_q      <= timeout_err_d;
    end
  end

  assign mem_request          = mem_request_q;
  assign mem_write_enable     = mem_write_enable_q;
  assign mem_address          = mem_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign p0_mem_ready         = p0_ready_q;
  assign p1_mem_ready         = p1_ready_q;
  assign p0_mem_response_data = p0_rdata_q;
  assign p1_mem_response_data = p1_rdata_q;
  assign timeout_err          = timeout_err_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed vector table, hand-written timeout/reset sequences,
// then random traffic checked against a transaction-level model.
module tb_l1_mem_arbiter;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] P0WD = 32'hAAAA_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_rdy, p1_rdy;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rdy;
  logic        terr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .p0_mem_request(p0_req), .p0_mem_write_enable(p0_we), .p0_mem_address(p0_addr),
    .p0_mem_write_data(p0_wdata), .p0_mem_response_data(p0_rdata), .p0_mem_ready(p0_rdy),
    .p1_mem_request(p1_req), .p1_mem_write_enable(p1_we), .p1_mem_address(p1_addr),
    .p1_mem_write_data(p1_wdata), .p1_mem_response_data(p1_rdata), .p1_mem_ready(p1_rdy),
    .mem_request(mem_req), .mem_write_enable(mem_we), .mem_address(mem_addr),
    .mem_write_data(mem_wdata), .mem_response_data(mem_rdata), .mem_ready(mem_rdy),
    .timeout_err(terr)
  );

  typedef struct {
    logic rst;
    logic p0r; logic p0w; logic [31:0] p0a;
    logic p1r; logic p1w; logic [31:0] p1a; logic [31:0] p1wd;
    logic mr; logic [31:0] md;
    logic emr; logic emw; logic [31:0] ema; logic [31:0] emwd;
    logic e0r; logic [31:0] e0d;
    logic e1r; logic [31:0] e1d;
  } vec_t;

  vec_t vecs[23];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = P0WD;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    mem_rdy = 0; mem_rdata = 0;
  endtask

  // random-phase state
  logic        rq[2], rw[2];
  logic [31:0] ra[2], rd[2];
  logic        s_r[2], s_w[2];
  logic [31:0] s_a[2], s_d[2];
  logic        s_mr;
  logic [31:0] s_md;
  logic        model_last, out_port, g_we;
  logic [31:0] g_addr, g_wdata;
  logic        prev_mreq, prev_idle, exp_mreq, rise, seen;
  logic        obs_rdy[2];
  int          exp_port, cnt, n_hi;

  initial begin
    rst = 1; idle_inputs();
    step(); step();
    chk1("reset_mem_req", mem_req, 0);
    chk1("reset_p0_rdy", p0_rdy, 0);
    chk1("reset_p1_rdy", p1_rdy, 0);
    chk32("reset_mem_addr", mem_addr, 0);
    chk1("reset_terr", terr, 0);
    rst = 0;

    vecs[0]  = '{N, Y,N,32'h40, N,N,0,0, N,0, Y,N,32'h40,P0WD, N,0, N,0};
    vecs[1]  = '{N, Y,N,32'h40, N,N,0,0, N,0, Y,N,32'h40,P0WD, N,0, N,0};
    vecs[2]  = '{N, Y,N,32'h40, N,N,0,0, N,0, Y,N,32'h40,P0WD, N,0, N,0};
    vecs[3]  = '{N, Y,N,32'h40, N,N,0,0, Y,32'hCAFE_0001, N,N,0,0, Y,32'hCAFE_0001, N,0};
    vecs[4]  = '{N, N,N,0, N,N,0,0, N,0, N,N,0,0, N,0, N,0};
    vecs[5]  = '{N, N,N,0, N,N,0,0, Y,32'hFFFF_FFFF, N,N,0,0, N,0, N,0};
    vecs[6]  = '{N, N,N,0, N,N,0,0, N,0, N,N,0,0, N,0, N,0};
    vecs[7]  = '{Y, N,N,0, N,N,0,0, N,0, N,N,0,0, N,0, N,0};
    vecs[8]  = '{N, Y,N,32'h100, Y,N,32'h200,0, N,0, Y,N,32'h100,P0WD, N,0, N,0};
    vecs[9]  = '{N, Y,N,32'h100, Y,N,32'h200,0, Y,32'h11, N,N,0,0, Y,32'h11, N,0};
    vecs[10] = '{N, Y,N,32'h300, Y,N,32'h200,0, N,0, N,N,0,0, N,0, N,0};
    vecs[11] = '{N, Y,N,32'h300, Y,N,32'h200,0, N,0, Y,N,32'h200,0, N,0, N,0};
    vecs[12] = '{N, Y,N,32'h300, Y,N,32'h200,0, Y,32'h22, N,N,0,0, N,0, Y,32'h22};
    vecs[13] = '{N, Y,N,32'h300, N,N,0,0, N,0, N,N,0,0, N,0, N,0};
    vecs[14] = '{N, Y,N,32'h300, N,N,0,0, N,0, Y,N,32'h300,P0WD, N,0, N,0};
    vecs[15] = '{N, Y,N,32'h300, N,N,0,0, Y,32'h33, N,N,0,0, Y,32'h33, N,0};
    vecs[16] = '{N, N,N,0, N,N,0,0, N,0, N,N,0,0, N,0, N,0};
    vecs[17] = '{N, N,N,0, Y,Y,32'h1004,32'h1234_5678, N,0, Y,Y,32'h1004,32'h1234_5678, N,0, N,0};
    vecs[18] = '{N, N,N,0, Y,Y,32'h1004,32'h1234_5678, Y,32'hDEAD, N,N,0,0, N,0, Y,0};
    vecs[19] = '{N, N,N,0, Y,N,32'h2000,0, N,0, N,N,0,0, N,0, N,0};
    vecs[20] = '{N, N,N,0, Y,N,32'h2000,0, N,0, Y,N,32'h2000,0, N,0, N,0};
    vecs[21] = '{N, N,N,0, Y,N,32'h2000,0, Y,32'h5555, N,N,0,0, N,0, Y,32'h5555};
    vecs[22] = '{N, N,N,0, N,N,0,0, N,0, N,N,0,0, N,0, N,0};

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      p0_req = vecs[i].p0r; p0_we = vecs[i].p0w; p0_addr = vecs[i].p0a;
      p1_req = vecs[i].p1r; p1_we = vecs[i].p1w; p1_addr = vecs[i].p1a; p1_wdata = vecs[i].p1wd;
      mem_rdy = vecs[i].mr; mem_rdata = vecs[i].md;
      step();
      chk1($sformatf("v%0d_mem_req", i), mem_req, vecs[i].emr);
      chk1($sformatf("v%0d_p0_rdy", i), p0_rdy, vecs[i].e0r);
      chk32($sformatf("v%0d_p0_data", i), p0_rdata, vecs[i].e0d);
      chk1($sformatf("v%0d_p1_rdy", i), p1_rdy, vecs[i].e1r);
      chk32($sformatf("v%0d_p1_data", i), p1_rdata, vecs[i].e1d);
      chk1($sformatf("v%0d_terr", i), terr, 0);
      if (vecs[i].emr) begin
        chk1($sformatf("v%0d_mem_we", i), mem_we, vecs[i].emw);
        chk32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ema);
        chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].emwd);
      end
    end
    rst = 0; idle_inputs();

    // Watchdog: memory never answers, expiry after 8 ISSUE cycles.
    p0_req = 1; p0_addr = 32'h80;
    seen = 0; n_hi = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (p0_rdy) begin
        seen = 1;
        chk32("t4_data", p0_rdata, 0);
        chk1("t4_terr", terr, 1);
        chk1("t4_p1_rdy", p1_rdy, 0);
      end else if (mem_req) begin
        n_hi++;
      end
    end
    chk1("t4_ready_seen", seen, 1);
    chk32("t4_issue_cycles", n_hi, 8);
    p0_req = 0;
    repeat (4) step();
    chk1("t4_terr_sticky", terr, 1);
    chk1("t4_idle_req", mem_req, 0);
    rst = 1; step(); rst = 0;
    chk1("t4_terr_cleared", terr, 0);

    // Reset two cycles into ISSUE abandons the transaction.
    p0_req = 1; p0_addr = 32'h500;
    step();
    chk1("t5_granted", mem_req, 1);
    step(); step();
    rst = 1; step(); rst = 0;
    chk1("t5_rst_mem_req", mem_req, 0);
    chk1("t5_rst_p0_rdy", p0_rdy, 0);
    chk1("t5_rst_p1_rdy", p1_rdy, 0);
    step();
    chk1("t5_regrant", mem_req, 1);
    chk32("t5_regrant_addr", mem_addr, 32'h500);
    mem_rdy = 1; mem_rdata = 32'h77;
    step();
    chk1("t5_p0_rdy", p0_rdy, 1);
    chk32("t5_p0_data", p0_rdata, 32'h77);
    mem_rdy = 0; p0_req = 0;
    step();
    chk1("t5_pulse_end", p0_rdy, 0);

    // Random traffic against a transaction-level model.
    rst = 1; idle_inputs(); step(); rst = 0;
    for (int k = 0; k < 2; k++) begin rq[k] = 0; rw[k] = 0; ra[k] = 0; rd[k] = 0; end
    model_last = 1; out_port = 0; g_we = 0; g_addr = 0; g_wdata = 0;
    prev_mreq = 0; prev_idle = 1; cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_r[0] = p0_req; s_w[0] = p0_we; s_a[0] = p0_addr; s_d[0] = p0_wdata;
      s_r[1] = p1_req; s_w[1] = p1_we; s_a[1] = p1_addr; s_d[1] = p1_wdata;
      s_mr = mem_rdy; s_md = mem_rdata;
      step();
      exp_mreq = prev_mreq ? !s_mr : (prev_idle && (s_r[0] || s_r[1]));
      chk1("rnd_mem_req", mem_req, exp_mreq);
      rise = exp_mreq && !prev_mreq;
      if (rise) begin
        out_port = (s_r[0] && s_r[1]) ? !model_last : s_r[1];
        model_last = out_port;
        g_we = s_w[out_port]; g_addr = s_a[out_port]; g_wdata = s_d[out_port];
      end
      if (exp_mreq) begin
        chk1("rnd_mem_we", mem_we, g_we);
        chk32("rnd_mem_addr", mem_addr, g_addr);
        chk32("rnd_mem_wdata", mem_wdata, g_wdata);
      end
      exp_port = (prev_mreq && s_mr) ? int'(out_port) : 2;
      chk1("rnd_p0_rdy", p0_rdy, exp_port == 0);
      chk1("rnd_p1_rdy", p1_rdy, exp_port == 1);
      chk32("rnd_p0_data", p0_rdata, (exp_port == 0 && !g_we) ? s_md : 32'h0);
      chk32("rnd_p1_data", p1_rdata, (exp_port == 1 && !g_we) ? s_md : 32'h0);
      chk1("rnd_terr", terr, 0);

      obs_rdy[0] = p0_rdy; obs_rdy[1] = p1_rdy;
      for (int k = 0; k < 2; k++) begin
        if (rq[k] && obs_rdy[k]) rq[k] = 0;
        if (!rq[k] && $urandom_range(0, 2) == 0) begin
          rq[k] = 1; rw[k] = $urandom_range(0, 1) == 1;
          ra[k] = $urandom; rd[k] = $urandom;
        end
      end
      p0_req = rq[0]; p0_we = rw[0]; p0_addr = ra[0]; p0_wdata = rd[0];
      p1_req = rq[1]; p1_we = rw[1]; p1_addr = ra[1]; p1_wdata = rd[1];

      if (mem_req && !prev_mreq) cnt = $urandom_range(0, 5);
      if (mem_req) begin
        if (cnt == 0) begin
          mem_rdy = 1; mem_rdata = $urandom;
        end else begin
          cnt--; mem_rdy = 0; mem_rdata = $urandom;
        end
      end else begin
        mem_rdy = ($urandom_range(0, 15) == 0); mem_rdata = $urandom;
      end
      prev_mreq = mem_req;
      prev_idle = !mem_req && !p0_rdy && !p1_rdy;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
